// File: rtl/vector_pkg.sv
// Shared types and constants for the vector display pipeline.
// No logic; the FSM state encodings are plain constants so older code can compare against them.
// Bank depth here is the default that the frame scheduler inherits.
package vector_pkg;

    localparam int FRAME_BANK_DEPTH = 512;

    // Writer (frame builder) states
    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE  = 2'd0;
    localparam wr_state_t W_BUILD = 2'd1;
    localparam wr_state_t W_FULL  = 2'd2;

    // Display states
    typedef logic [0:0] disp_state_t;
    localparam disp_state_t D_IDLE = 1'b0;
    localparam disp_state_t D_DRAW = 1'b1;

endpackage

// File: rtl/build_watchdog.sv
// Cycle counter that flags a frame build which has run too long.
// Latency: expired asserts WDOG_CYCLES-1 enabled cycles after the last clear.
// No backpressure; the counter holds at the limit until cleared.
module build_watchdog #(
    parameter int unsigned WDOG_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles since the last clear, saturating at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffer sequencer: requests frame builds into one bank while the display draws the other.
// Latency: build_done -> go/new bases two cycles later; halt -> go low next cycle, redraw/swap one after.
// Backpressure: a finished build waits in W_FULL until the display's current pass ends.
module frame_scheduler
    import vector_pkg::*;
#(
    parameter int ADDRESSWIDTH = 16,
    parameter int BANK_DEPTH   = FRAME_BANK_DEPTH,
    parameter int WDOG_CYCLES  = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    build_req,
    input  logic                    build_done,
    input  logic [ADDRESSWIDTH-1:0] build_len,
    output logic                    go,
    input  logic                    halt,
    output logic [ADDRESSWIDTH-1:0] wr_base,
    output logic [ADDRESSWIDTH-1:0] rd_base,
    output logic [ADDRESSWIDTH-1:0] frame_len,
    output logic [7:0]              frame_cnt,
    output logic                    wdog_err
);

    localparam logic [ADDRESSWIDTH-1:0] DEPTH_W = ADDRESSWIDTH'(BANK_DEPTH);

    function automatic logic [ADDRESSWIDTH-1:0] bank_base(input logic bank);
        return bank ? DEPTH_W : '0;
    endfunction

    wr_state_t               w_state;
    disp_state_t             d_state;
    logic                    bank_wr;
    logic                    bank_rd;
    logic [ADDRESSWIDTH-1:0] pend_len;
    logic [ADDRESSWIDTH-1:0] clamp_len;
    logic                    swap;
    logic                    redraw;
    logic                    wd_expired;

    // A finished frame always wins over re-showing the old one
    assign swap      = (d_state == D_IDLE) && (w_state == W_FULL);
    assign redraw    = (d_state == D_IDLE) && (w_state != W_FULL) && (frame_len != '0);
    assign clamp_len = (build_len > DEPTH_W) ? DEPTH_W : build_len;

    build_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_state == W_IDLE),
        .en      (w_state == W_BUILD),
        .expired (wd_expired)
    );

    // Writer FSM: request a build, wait for it, then hold the result until the display swaps it in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            build_req <= 1'b0;
            wdog_err  <= 1'b0;
            pend_len  <= '0;
        end else begin
            build_req <= 1'b0;
            wdog_err  <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    build_req <= 1'b1;
                    w_state   <= W_BUILD;
                end
                W_BUILD: begin
                    // A completion arriving on the expiry cycle is still accepted
                    if (build_done) begin
                        if (build_len == '0) begin
                            w_state <= W_IDLE;
                        end else begin
                            pend_len <= clamp_len;
                            w_state  <= W_FULL;
                        end
                    end else if (wd_expired) begin
                        wdog_err <= 1'b1;
                        w_state  <= W_IDLE;
                    end
                end
                W_FULL: begin
                    if (swap) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Display FSM: hand a bank to the display, swapping in a new frame or redrawing the last one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_state   <= D_IDLE;
            go        <= 1'b0;
            bank_wr   <= 1'b0;
            bank_rd   <= 1'b1;
            wr_base   <= '0;
            rd_base   <= DEPTH_W;
            frame_len <= '0;
            frame_cnt <= '0;
        end else begin
            case (d_state)
                D_IDLE: begin
                    if (swap) begin
                        // bank_rd is always ~bank_wr, so the new write bank is the old read bank
                        bank_rd   <= bank_wr;
                        bank_wr   <= ~bank_wr;
                        rd_base   <= bank_base(bank_wr);
                        wr_base   <= bank_base(bank_rd);
                        frame_len <= pend_len;
                        go        <= 1'b1;
                        d_state   <= D_DRAW;
                    end else if (redraw) begin
                        go      <= 1'b1;
                        d_state <= D_DRAW;
                    end
                end
                D_DRAW: begin
                    if (halt) begin
                        go        <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                        d_state   <= D_IDLE;
                    end
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus pushes expected events, a monitor pops and compares.
// Events are go rising edges, build_req pulses and wdog_err pulses, each tagged with its expected cycle.
// Watchdog limit is 16 so the timeout path is reachable in a short run.
module tb_frame_scheduler;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          build_done = 1'b0;
    logic          halt = 1'b0;
    logic [AW-1:0] build_len = '0;
    logic          build_req;
    logic          go;
    logic          wdog_err;
    logic [AW-1:0] wr_base;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] frame_len;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    frame_scheduler #(
        .ADDRESSWIDTH (AW),
        .BANK_DEPTH   (512),
        .WDOG_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .build_req  (build_req),
        .build_done (build_done),
        .build_len  (build_len),
        .go         (go),
        .halt       (halt),
        .wr_base    (wr_base),
        .rd_base    (rd_base),
        .frame_len  (frame_len),
        .frame_cnt  (frame_cnt),
        .wdog_err   (wdog_err)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [7:0]    cnt;
    } exp_t;

    exp_t goq[$];
    exp_t reqq[$];
    exp_t wdq[$];

    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    logic          prev_go = 1'b0;
    logic [AW-1:0] prev_rd = '0;
    logic [AW-1:0] prev_len = '0;
    exp_t          e;
    int            c0;
    int            c2;

    function automatic exp_t mk(input int c, input int b, input int l, input int n);
        exp_t r;
        r.cyc  = c;
        r.base = AW'(b);
        r.len  = AW'(l);
        r.cnt  = 8'(n);
        return r;
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive one-cycle input pulses starting at the current negedge
    task automatic pulse(input logic d, input int len, input logic h);
        build_done = d;
        build_len  = AW'(len);
        halt       = h;
        @(negedge clk);
        build_done = 1'b0;
        halt       = 1'b0;
    endtask

    // Monitor: sample 1 ns after each rising edge and match DUT events against the queues
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (go && !prev_go) begin
                if (goq.size() == 0) begin
                    chk("go_unexpected", cyc, -1);
                end else begin
                    e = goq.pop_front();
                    chk("go_cycle", cyc, e.cyc);
                    chk("go_rd_base", rd_base, e.base);
                    chk("go_frame_len", frame_len, e.len);
                    chk("go_frame_cnt", frame_cnt, e.cnt);
                end
            end
            if (go && prev_go) begin
                chk("draw_rd_base_stable", rd_base, prev_rd);
                chk("draw_len_stable", frame_len, prev_len);
            end
            if (build_req) begin
                if (reqq.size() == 0) begin
                    chk("build_req_unexpected", cyc, -1);
                end else begin
                    e = reqq.pop_front();
                    chk("build_req_cycle", cyc, e.cyc);
                    chk("build_req_wr_base", wr_base, e.base);
                end
            end
            if (wdog_err) begin
                if (wdq.size() == 0) begin
                    chk("wdog_unexpected", cyc, -1);
                end else begin
                    e = wdq.pop_front();
                    chk("wdog_cycle", cyc, e.cyc);
                    chk("wdog_wr_base", wr_base, e.base);
                end
            end
            prev_go  = go;
            prev_rd  = rd_base;
            prev_len = frame_len;
        end
    end

    // Stimulus: directed scenarios with hand-computed event cycles relative to reset release
    initial begin
        wait_cyc(1);
        chk("rst_go", go, 0);
        chk("rst_build_req", build_req, 0);
        chk("rst_wdog_err", wdog_err, 0);
        chk("rst_wr_base", wr_base, 0);
        chk("rst_rd_base", rd_base, 512);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        wait_cyc(3);
        c0  = cyc;
        rst = 1'b1;
        reqq.push_back(mk(c0 + 1, 0, 0, 0));

        // First build of 40 words: swap into display, second request into bank 1
        wait_cyc(c0 + 4);
        goq.push_back(mk(c0 + 6, 0, 40, 0));
        reqq.push_back(mk(c0 + 7, 512, 0, 0));
        pulse(1'b1, 40, 1'b0);

        // Pass ends with nothing pending: redraw same bank after a one-cycle gap
        wait_cyc(c0 + 8);
        goq.push_back(mk(c0 + 10, 0, 40, 1));
        pulse(1'b0, 0, 1'b1);
        chk("halt_go_low", go, 0);
        chk("halt_frame_cnt", frame_cnt, 1);

        // Oversized build finishes mid-draw: held until halt, then clamped to 512
        wait_cyc(c0 + 12);
        pulse(1'b1, 700, 1'b0);
        wait_cyc(c0 + 15);
        goq.push_back(mk(c0 + 17, 512, 512, 2));
        reqq.push_back(mk(c0 + 18, 0, 0, 0));
        pulse(1'b0, 0, 1'b1);

        // build_done and halt together: swap lands two cycles later
        wait_cyc(c0 + 20);
        goq.push_back(mk(c0 + 22, 0, 100, 3));
        reqq.push_back(mk(c0 + 23, 512, 0, 0));
        pulse(1'b1, 100, 1'b1);
        chk("coincident_go_low", go, 0);

        // Empty build is discarded and re-requested; then no completion triggers the watchdog
        wait_cyc(c0 + 25);
        reqq.push_back(mk(c0 + 27, 512, 0, 0));
        pulse(1'b1, 0, 1'b0);
        wdq.push_back(mk(c0 + 43, 512, 0, 0));
        reqq.push_back(mk(c0 + 44, 512, 0, 0));

        // Asynchronous reset mid-draw
        wait_cyc(c0 + 46);
        chk("pre_reset_go", go, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_go", go, 0);
        chk("async_rst_wr_base", wr_base, 0);
        chk("async_rst_rd_base", rd_base, 512);
        chk("async_rst_frame_len", frame_len, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        wait_cyc(c0 + 48);
        c2  = cyc;
        rst = 1'b1;
        reqq.push_back(mk(c2 + 1, 0, 0, 0));

        wait_cyc(c2 + 4);
        chk("go_events_outstanding", goq.size(), 0);
        chk("req_events_outstanding", reqq.size(), 0);
        chk("wdog_events_outstanding", wdq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
